grf_write_arbiter: RTL
======================

# grf_write_arbiter

Shares the single GRF write port between the pipeline write-back stage and the multi-cycle multiply/divide unit (MDU). Pipeline writes always win. MDU results wait in a small in-order queue and drain into free cycles. If the MDU head waits too long, the block asks the hazard unit to stall the pipeline. It sits between W-stage/MDU and the GRF write inputs (RegWrite, RD, WD, WPC) and exports a pending-register mask for hazard detection.

## Interface
Parameters:
- DEPTH, 2, MDU queue entries (power of two, ≥2)
- MAX_WAIT, 4, cycles the queue head may wait before stall_req asserts (≥1)

Ports:
- CLK  in  1  clock; all state updates on posedge
- Reset  in  1  synchronous, active-high
- pipe_we  in  1  W-stage write request; cannot be stalled
- pipe_rd  in  5  W-stage destination register
- pipe_wd  in  32  W-stage write data
- pipe_pc  in  32  W-stage instruction PC
- mdu_valid  in  1  MDU result offered
- mdu_rd  in  5  MDU destination register
- mdu_wd  in  32  MDU result data
- mdu_pc  in  32  MDU instruction PC
- mdu_ready  out  1  queue can accept; transfer when mdu_valid & mdu_ready
- grf_we  out  1  to GRF RegWrite, registered
- grf_rd  out  5  to GRF RD, registered
- grf_wd  out  32  to GRF WD, registered
- grf_wpc  out  32  to GRF WPC, registered
- pending_mask  out  32  bit r set iff a valid queued entry targets $r
- stall_req  out  1  to hazard unit: insert a bubble this cycle

## Operation
- A pipe request is effective when pipe_we=1 and pipe_rd≠0.
- An MDU transfer with mdu_rd=0 is accepted and then discarded. It is never enqueued.
- Queue: circular FIFO, DEPTH entries of {valid, rd, wd, pc}.
- mdu_ready = !full & !Reset.
- Per-cycle grant, combinational on current state:
  - An effective pipe request is granted.
  - Otherwise, if the head is valid, the head is granted and popped.
  - Otherwise, if the head is invalid (squashed), it is popped with no grant.
  - The grant is registered into grf_* on the next edge. With no grant, grf_we=0 and grf_rd/wd/wpc hold their last values.
- Squash: a granted pipe write to $r is younger than all queued MDU results.
  - Same edge: clear valid on every queued entry with rd=r.
  - An incoming MDU transfer to $r in that same cycle is accepted but not enqueued.
- Wait counter tracks cycles the valid head was refused. States:
  - EMPTY: no valid entries.
  - QUEUED: wait < MAX_WAIT.
  - STARVED: wait ≥ MAX_WAIT; stall_req=1.
- Transitions:
  - EMPTY→QUEUED when a valid entry becomes head.
  - QUEUED→STARVED when wait reaches MAX_WAIT.
  - Any state→EMPTY or QUEUED on head pop. Wait clears to 0 on every pop.
- In STARVED the pipeline is expected to present pipe_we=0 next cycle. A pipe request that arrives anyway still wins.
- Simultaneous enqueue and pop are allowed in the same cycle. When full, mdu_ready=0 even if a pop occurs that cycle.

## Timing
- Reset values:
  - grf_we=0, grf_rd=0, grf_wd=0, grf_wpc=0.
  - Queue empty, all valid bits 0, wait=0.
  - pending_mask=0, stall_req=0.
  - mdu_ready=0 during the Reset cycle and 1 on the first cycle after.
- Reset mid-operation discards all queued results without writing them.
- Pipe latency: request in cycle t → grf_we=1 in cycle t+1 → GRF updates at the end of t+1.
- MDU latency: accepted in cycle t → earliest grf_we in cycle t+2 (enqueue at edge t, grant in t+1).
- pending_mask and stall_req are decoded from registered state only. They never depend combinationally on the current cycle's inputs.
- A pending_mask bit clears on the edge where its entry is popped or squashed.

## Structure
- Shared package: reg-index width (5), data width (32), queue-entry struct {valid, rd, wd, pc}, arbiter state encoding (EMPTY/QUEUED/STARVED).
- One sub-module: wb_queue, the DEPTH-entry FIFO. It owns head/tail pointers with a wrap bit and supports per-entry squash by rd match.
- Arbitration, wait counter and output registers live in the top.

## Test plan
- Pipe-only: pipe_we=1, pipe_rd=5, pipe_wd=0x1234 in cycle 3 → cycle 4 grf_we=1, grf_rd=5, grf_wd=0x1234, grf_wpc=pipe_pc; pending_mask stays 0.
- MDU drain: MDU $8=0xAAAA accepted in cycle 2 with the pipe idle → pending_mask bit 8 set in cycle 3; grf_we=1, rd=8 in cycle 4; mask clear in cycle 4.
- Conflict/starvation (MAX_WAIT=4): queue $9 and hold pipe_we=1 (rd=3) continuously → stall_req=1 after 4 refused cycles; drop pipe_we → $9 granted next cycle, stall_req=0 after pop.
- Full queue (DEPTH=2): two MDU transfers while the pipe is busy → mdu_ready=0; a third mdu_valid is held and accepted only after a pop.
- Squash: queue $7=0x1, then pipe writes $7=0x2 → no GRF write of 0x1 ever; bit 7 clears at the pipe grant edge; the final GRF value of $7 is 0x2.
- $0 and reset: MDU rd=0 → accepted, never written. Assert Reset with 2 entries queued → next cycle queue empty, all outputs 0, no grf_we pulse.

Source files
------------

// File: rtl/grf_write_arbiter_pkg.sv
// grf_write_arbiter_pkg
// Shared types and constants for the GRF write-port arbiter.
//   REG_W / DATA_W / NUM_REGS : register index width, data width, register count
//   wb_entry_t                : one queued MDU write-back {valid, rd, wd, pc}
//   arb_state_t               : arbiter state (EMPTY / QUEUED / STARVED)
//   reg_onehot()              : decodes a register index into a 32-bit mask
package grf_write_arbiter_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;

    typedef enum logic [1:0] {
        ARB_EMPTY   = 2'd0,
        ARB_QUEUED  = 2'd1,
        ARB_STARVED = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] rd);
        reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << rd;
    endfunction

endpackage

// File: rtl/grf_write_arbiter_wb_queue.sv
// wb_queue
// In-order FIFO of pending MDU write-backs. Entries keep their slot until
// popped; a squash only drops the valid bit, so squashed entries still
// occupy the FIFO and are popped later without producing a write.
// Ports:
//   CLK, Reset       clock, synchronous active-high reset
//   push, push_*     enqueue one valid entry at the tail (caller ensures !full)
//   pop              remove the head entry (caller ensures !empty)
//   squash, squash_rd clear valid on every entry whose rd matches
//   full, empty      occupancy flags (squashed entries count as occupied)
//   head             current head entry (valid=0 when empty or squashed)
//   any_valid_next   at least one valid entry will remain after this edge
//   pending_mask     bit r set iff a valid entry targets $r (registered state)
module wb_queue
    import grf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                push,
    input  logic [REG_W-1:0]    push_rd,
    input  logic [DATA_W-1:0]   push_wd,
    input  logic [DATA_W-1:0]   push_pc,
    input  logic                pop,
    input  logic                squash,
    input  logic [REG_W-1:0]    squash_rd,
    output logic                full,
    output logic                empty,
    output wb_entry_t           head,
    output logic                any_valid_next,
    output logic [NUM_REGS-1:0] pending_mask
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]    head_ptr_r;
    logic [PW-1:0]    tail_ptr_r;
    wb_entry_t        mem_r [DEPTH];
    logic [DEPTH-1:0] valid_nxt_s;
    logic [DEPTH-1:0] fill_s;

    // Occupancy flags and head read-out.
    always_comb begin
        empty = (head_ptr_r == tail_ptr_r);
        full  = (head_ptr_r[AW] != tail_ptr_r[AW]) &&
                (head_ptr_r[AW-1:0] == tail_ptr_r[AW-1:0]);
        head  = mem_r[head_ptr_r[AW-1:0]];
    end

    // Next valid bit per slot: a push fills the tail slot, pop or squash kills.
    always_comb begin
        valid_nxt_s = {DEPTH{1'b0}};
        fill_s      = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            fill_s[i]      = push & (tail_ptr_r[AW-1:0] == AW'(i));
            valid_nxt_s[i] = fill_s[i] |
                             (mem_r[i].valid &
                              !(squash & (mem_r[i].rd == squash_rd)) &
                              !(pop & (head_ptr_r[AW-1:0] == AW'(i))));
        end
        any_valid_next = |valid_nxt_s;
    end

    // Pending-register mask decoded from stored entries only.
    always_comb begin
        pending_mask = {NUM_REGS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_r[i].valid) begin
                pending_mask = pending_mask | reg_onehot(mem_r[i].rd);
            end else begin
                pending_mask = pending_mask;
            end
        end
    end

    // Storage and pointer update.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            head_ptr_r <= {PW{1'b0}};
            tail_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i].valid <= valid_nxt_s[i];
                if (fill_s[i]) begin
                    mem_r[i].rd <= push_rd;
                    mem_r[i].wd <= push_wd;
                    mem_r[i].pc <= push_pc;
                end
            end
            if (push) begin
                tail_ptr_r <= tail_ptr_r + PTR_ONE;
            end
            if (pop) begin
                head_ptr_r <= head_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter
// Shares the single GRF write port between the W-stage and the MDU.
// Pipeline writes always win; MDU results wait in wb_queue and drain into
// free cycles. A pipeline write to $r squashes every queued MDU result for
// $r, since the pipeline instruction is younger. If the valid queue head is
// refused MAX_WAIT times, stall_req asks the hazard unit for a bubble.
// Ports:
//   CLK, Reset                   clock, synchronous active-high reset
//   pipe_we/rd/wd/pc             W-stage write request (never stalled)
//   mdu_valid/rd/wd/pc           MDU result offer
//   mdu_ready                    queue can accept this cycle
//   grf_we/rd/wd/wpc             registered GRF write port
//   pending_mask                 registers with a valid queued MDU result
//   stall_req                    head starved, request a pipeline bubble
module grf_write_arbiter
    import grf_write_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                pipe_we,
    input  logic [REG_W-1:0]    pipe_rd,
    input  logic [DATA_W-1:0]   pipe_wd,
    input  logic [DATA_W-1:0]   pipe_pc,
    input  logic                mdu_valid,
    input  logic [REG_W-1:0]    mdu_rd,
    input  logic [DATA_W-1:0]   mdu_wd,
    input  logic [DATA_W-1:0]   mdu_pc,
    output logic                mdu_ready,
    output logic                grf_we,
    output logic [REG_W-1:0]    grf_rd,
    output logic [DATA_W-1:0]   grf_wd,
    output logic [DATA_W-1:0]   grf_wpc,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                stall_req
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_ONE = {{(WW-1){1'b0}}, 1'b1};

    logic                q_full_s;
    logic                q_empty_s;
    wb_entry_t           q_head_s;
    logic                q_any_valid_nxt_s;
    logic [NUM_REGS-1:0] q_mask_s;

    logic                pipe_eff_s;
    logic                xfer_s;
    logic                push_s;
    logic                pop_s;
    logic                head_grant_s;
    logic                refused_s;
    logic [WW-1:0]       wait_r;
    logic [WW-1:0]       wait_nxt_s;
    arb_state_t          state_r;
    arb_state_t          state_nxt_s;

    logic                grf_we_r;
    logic [REG_W-1:0]    grf_rd_r;
    logic [DATA_W-1:0]   grf_wd_r;
    logic [DATA_W-1:0]   grf_wpc_r;

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .CLK            (CLK),
        .Reset          (Reset),
        .push           (push_s),
        .push_rd        (mdu_rd),
        .push_wd        (mdu_wd),
        .push_pc        (mdu_pc),
        .pop            (pop_s),
        .squash         (pipe_eff_s),
        .squash_rd      (pipe_rd),
        .full           (q_full_s),
        .empty          (q_empty_s),
        .head           (q_head_s),
        .any_valid_next (q_any_valid_nxt_s),
        .pending_mask   (q_mask_s)
    );

    // Grant decision and queue handshake for the current cycle.
    always_comb begin
        pipe_eff_s   = pipe_we & (pipe_rd != 5'd0);
        mdu_ready    = !q_full_s & !Reset;
        xfer_s       = mdu_valid & mdu_ready;
        // $0 results and results overtaken by this cycle's pipe write are
        // accepted from the MDU but never stored.
        push_s       = xfer_s & (mdu_rd != 5'd0) &
                       !(pipe_eff_s & (mdu_rd == pipe_rd));
        // The head leaves whenever the port is free, valid or squashed.
        pop_s        = !pipe_eff_s & !q_empty_s;
        head_grant_s = pop_s & q_head_s.valid;
        // A head squashed by the winning pipe write is not counted as refused.
        refused_s    = pipe_eff_s & q_head_s.valid & (q_head_s.rd != pipe_rd);
    end

    // Wait counter: saturating count of refusals, cleared by any pop.
    always_comb begin
        wait_nxt_s = wait_r;
        if (pop_s) begin
            wait_nxt_s = {WW{1'b0}};
        end else if (refused_s && (wait_r < WAIT_MAX)) begin
            wait_nxt_s = wait_r + WAIT_ONE;
        end else begin
            wait_nxt_s = wait_r;
        end
    end

    // Next arbiter state follows the queue contents and wait count after
    // this edge; the rule is the same from every state.
    always_comb begin
        state_nxt_s = ARB_EMPTY;
        if (!q_any_valid_nxt_s) begin
            state_nxt_s = ARB_EMPTY;
        end else if (wait_nxt_s >= WAIT_MAX) begin
            state_nxt_s = ARB_STARVED;
        end else begin
            state_nxt_s = ARB_QUEUED;
        end
    end

    // Arbiter state and wait counter registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= ARB_EMPTY;
            wait_r  <= {WW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            wait_r  <= wait_nxt_s;
        end
    end

    // GRF write-port registers; address/data hold when nothing is granted.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            grf_we_r  <= 1'b0;
            grf_rd_r  <= 5'd0;
            grf_wd_r  <= 32'd0;
            grf_wpc_r <= 32'd0;
        end else if (pipe_eff_s) begin
            grf_we_r  <= 1'b1;
            grf_rd_r  <= pipe_rd;
            grf_wd_r  <= pipe_wd;
            grf_wpc_r <= pipe_pc;
        end else if (head_grant_s) begin
            grf_we_r  <= 1'b1;
            grf_rd_r  <= q_head_s.rd;
            grf_wd_r  <= q_head_s.wd;
            grf_wpc_r <= q_head_s.pc;
        end else begin
            grf_we_r  <= 1'b0;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        grf_we       = grf_we_r;
        grf_rd       = grf_rd_r;
        grf_wd       = grf_wd_r;
        grf_wpc      = grf_wpc_r;
        pending_mask = q_mask_s;
        stall_req    = (state_r == ARB_STARVED);
    end

endmodule
